// File: rtl/clk_cfg_apb_sequencer.sv
// APB initiator: programs the clock/reset generator, polls lock status, then releases cluster reset.
// Optional readback of every configuration write when CLK_CFG_READBACK_EN is defined.
module clk_cfg_apb_sequencer #(
    parameter int unsigned NUM_WR    = 4,
    parameter logic [31:0] POLL_ADDR = 32'h0000_0010,
    parameter logic [31:0] LOCK_MASK = 32'h0000_0003,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned MAX_POLLS = 256,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [NUM_WR*32-1:0]  cfg_addr_i,
    input  logic [NUM_WR*32-1:0]  cfg_data_i,
    output logic [31:0]           paddr_o,
    output logic [31:0]           pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [31:0]           prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o,
    output logic                  rstn_cluster_o
);

    localparam int unsigned IW = $clog2(NUM_WR + 1);
    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SLV   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_POLLS = 2'd3;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WR_SETUP    = 4'd1,
        WR_ACCESS   = 4'd2,
        POLL_SETUP  = 4'd3,
        POLL_ACCESS = 4'd4,
        POLL_WAIT   = 4'd5,
        DONE        = 4'd6,
        ERROR       = 4'd7
`ifdef CLK_CFG_READBACK_EN
        ,
        RB_SETUP    = 4'd8,
        RB_ACCESS   = 4'd9
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [1:0]     err_q, err_d;

    logic [31:0]    cur_addr;
    logic [31:0]    cur_data;
    logic           last_wr;
    logic           tmo_hit;
    logic           locked;
    state_e         after_wr;

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int k = 0; k < int'(NUM_WR); k++) begin
            if (idx_q == IW'(k)) begin
                cur_addr = cfg_addr_i[32*k +: 32];
                cur_data = cfg_data_i[32*k +: 32];
            end
        end
    end

    assign last_wr  = (idx_q == IW'(NUM_WR - 1));
    assign tmo_hit  = !pready_i && (tmo_q == TW'(TIMEOUT - 1));
    assign locked   = ((prdata_i & LOCK_MASK) == LOCK_MASK);
    assign after_wr = last_wr ? POLL_SETUP : WR_SETUP;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        poll_d         = poll_q;
        tmo_d          = tmo_q;
        gap_d          = gap_q;
        err_d          = err_q;
        psel_o         = 1'b0;
        penable_o      = 1'b0;
        pwrite_o       = 1'b0;
        paddr_o        = '0;
        pwdata_o       = '0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        error_o        = 1'b0;
        rstn_cluster_o = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                done_o         = (state_q == DONE);
                rstn_cluster_o = (state_q == DONE);
                error_o        = (state_q == ERROR);
                if (start_i) begin
                    state_d = WR_SETUP;
                    idx_d   = '0;
                    poll_d  = '0;
                    tmo_d   = '0;
                    gap_d   = '0;
                    err_d   = ERR_NONE;
                end
            end

            WR_SETUP: begin
                busy_o   = 1'b1;
                psel_o   = 1'b1;
                pwrite_o = 1'b1;
                paddr_o  = cur_addr;
                pwdata_o = cur_data;
                tmo_d    = '0;
                state_d  = WR_ACCESS;
            end

            WR_ACCESS: begin
                busy_o    = 1'b1;
                psel_o    = 1'b1;
                penable_o = 1'b1;
                pwrite_o  = 1'b1;
                paddr_o   = cur_addr;
                pwdata_o  = cur_data;
                if (pready_i) begin
                    tmo_d = '0;
                    if (pslverr_i) begin
                        state_d = ERROR;
                        err_d   = ERR_SLV;
                    end else begin
`ifdef CLK_CFG_READBACK_EN
                        state_d = RB_SETUP;
`else
                        idx_d   = idx_q + IW'(1);
                        state_d = after_wr;
`endif
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

`ifdef CLK_CFG_READBACK_EN
            RB_SETUP: begin
                busy_o  = 1'b1;
                psel_o  = 1'b1;
                paddr_o = cur_addr;
                tmo_d   = '0;
                state_d = RB_ACCESS;
            end

            RB_ACCESS: begin
                busy_o    = 1'b1;
                psel_o    = 1'b1;
                penable_o = 1'b1;
                paddr_o   = cur_addr;
                if (pready_i) begin
                    tmo_d = '0;
                    // a readback mismatch is reported like a slave error
                    if (pslverr_i || (prdata_i != cur_data)) begin
                        state_d = ERROR;
                        err_d   = ERR_SLV;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = after_wr;
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`endif

            POLL_SETUP: begin
                busy_o  = 1'b1;
                psel_o  = 1'b1;
                paddr_o = POLL_ADDR;
                tmo_d   = '0;
                state_d = POLL_ACCESS;
            end

            POLL_ACCESS: begin
                busy_o    = 1'b1;
                psel_o    = 1'b1;
                penable_o = 1'b1;
                paddr_o   = POLL_ADDR;
                if (pready_i) begin
                    tmo_d = '0;
                    if (pslverr_i) begin
                        state_d = ERROR;
                        err_d   = ERR_SLV;
                    end else if (locked) begin
                        state_d = DONE;
                    end else if (poll_q == PW'(MAX_POLLS - 1)) begin
                        poll_d  = poll_q + PW'(1);
                        state_d = ERROR;
                        err_d   = ERR_POLLS;
                    end else begin
                        poll_d  = poll_q + PW'(1);
                        gap_d   = '0;
                        state_d = (POLL_GAP == 0) ? POLL_SETUP : POLL_WAIT;
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            POLL_WAIT: begin
                busy_o = 1'b1;
                gap_d  = gap_q + GW'(1);
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    state_d = POLL_SETUP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err_code_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            poll_q  <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_cfg_apb_sequencer.sv
// Testbench for clk_cfg_apb_sequencer: behavioural APB slave plus a
// transfer-level model of the expected bus traffic and completion time.
module tb_clk_cfg_apb_sequencer;

    localparam int N    = 4;
    localparam int GAP  = 16;
    localparam int MAXP = 4;
    localparam int TMO  = 8;
    localparam logic [31:0] PADR = 32'h0000_0010;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic [N*32-1:0] cfg_addr_i = '0;
    logic [N*32-1:0] cfg_data_i = '0;
    logic [31:0]     paddr_o;
    logic [31:0]     pwdata_o;
    logic            pwrite_o;
    logic            psel_o;
    logic            penable_o;
    logic [31:0]     prdata_i = '0;
    logic            pready_i = 1'b0;
    logic            pslverr_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic            error_o;
    logic [1:0]      err_code_o;
    logic            rstn_cluster_o;

    clk_cfg_apb_sequencer #(
        .NUM_WR    (N),
        .POLL_ADDR (PADR),
        .LOCK_MASK (32'h0000_0003),
        .POLL_GAP  (GAP),
        .MAX_POLLS (MAXP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_data_i     (cfg_data_i),
        .paddr_o        (paddr_o),
        .pwdata_o       (pwdata_o),
        .pwrite_o       (pwrite_o),
        .psel_o         (psel_o),
        .penable_o      (penable_o),
        .prdata_i       (prdata_i),
        .pready_i       (pready_i),
        .pslverr_i      (pslverr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .err_code_o     (err_code_o),
        .rstn_cluster_o (rstn_cluster_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } rec_t;

    // slave knobs, written only by the stimulus block
    int          waits [64];
    int          err_on;
    int          hang_on;
    int          lock_after;
    bit          arm = 1'b0;
    logic [31:0] wa [N];
    logic [31:0] wd [N];

    // slave state, written only by the slave block
    int          xfer_n = 0;
    int          poll_n = 0;
    int          wait_left = 0;
    int          stab_bad = 0;
    int          psel_cnt = 0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_wr = 1'b0;
    logic [31:0] v;
    rec_t        r;
    rec_t        mon_q [$];

    always @(negedge clk) begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = '0;
        if (arm) begin
            xfer_n = 0;
            poll_n = 0;
            wait_left = 0;
            stab_bad = 0;
            psel_cnt = 0;
            mon_q.delete();
        end
        if (psel_o) psel_cnt++;
        if (penable_o && !psel_o) stab_bad++;
        if (psel_o && !penable_o) begin
            s_addr = paddr_o;
            s_data = pwdata_o;
            s_wr = pwrite_o;
            wait_left = waits[xfer_n % 64];
        end else if (psel_o && penable_o) begin
            if (paddr_o !== s_addr || pwdata_o !== s_data || pwrite_o !== s_wr)
                stab_bad++;
            if (xfer_n == hang_on) begin
                pready_i = 1'b0;
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                pready_i  = 1'b1;
                pslverr_i = (xfer_n == err_on);
                if (!pwrite_o) begin
                    v = $urandom;
                    if (poll_n >= lock_after) v = v | 32'h3;
                    else if ($urandom_range(0, 1) == 0) v[0] = 1'b0;
                    else v[1] = 1'b0;
                    prdata_i = v;
                    poll_n++;
                end
                r.c = cyc;
                r.wr = pwrite_o;
                r.a = paddr_o;
                r.d = pwdata_o;
                mon_q.push_back(r);
                xfer_n++;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_knobs();
        for (int i = 0; i < 64; i++) waits[i] = 0;
        err_on = -1;
        hang_on = -1;
        lock_after = 0;
        for (int k = 0; k < N; k++) begin
            wa[k] = $urandom;
            wd[k] = $urandom;
            cfg_addr_i[32*k +: 32] = wa[k];
            cfg_data_i[32*k +: 32] = wd[k];
        end
    endtask

    task automatic run_case(input string nm, input int poke_at);
        int          exp_c [$];
        logic        exp_w [$];
        logic [31:0] exp_a [$];
        logic [31:0] exp_d [$];
        int          cy;
        int          code;
        int          p;
        int          s;
        int          pc;
        int          nchk;
        bit          fin;
        bit          wr;
        cy = 1;
        code = 0;
        p = 0;
        fin = 1'b0;
        // expected traffic: N writes in order, then polls of the status register
        for (int t = 0; !fin && t < 64; t++) begin
            wr = (t < N);
            if (t == hang_on) begin
                cy += 1 + TMO;
                code = 2;
                fin = 1'b1;
            end else begin
                cy += 2 + waits[t];
                exp_c.push_back(cy - 1);
                exp_w.push_back(wr);
                if (wr) begin
                    exp_a.push_back(wa[t]);
                    exp_d.push_back(wd[t]);
                end else begin
                    exp_a.push_back(PADR);
                    exp_d.push_back(32'h0);
                end
                if (t == err_on) begin
                    code = 1;
                    fin = 1'b1;
                end else if (!wr) begin
                    if (p >= lock_after) begin
                        fin = 1'b1;
                    end else begin
                        p++;
                        if (p == MAXP) begin
                            code = 3;
                            fin = 1'b1;
                        end else begin
                            cy += GAP;
                        end
                    end
                end
            end
        end

        @(posedge clk); #1;
        arm = 1'b1;
        start_i = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        arm = 1'b0;
        start_i = 1'b0;
        chk({nm, ":busy"}, busy_o, 1);
        chk({nm, ":done_clr"}, done_o, 0);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done_o || error_o) break;
            start_i = (cyc - s == poke_at);
        end
        start_i = 1'b0;
        chk({nm, ":end_cycle"}, cyc - s, cy);
        chk({nm, ":done"}, done_o, (code == 0));
        chk({nm, ":error"}, error_o, (code != 0));
        chk({nm, ":err_code"}, err_code_o, code);
        chk({nm, ":rstn_cluster"}, rstn_cluster_o, (code == 0));
        chk({nm, ":busy_end"}, busy_o, 0);
        chk({nm, ":psel_end"}, psel_o, 0);
        chk({nm, ":penable_end"}, penable_o, 0);
        chk({nm, ":n_xfer"}, mon_q.size(), exp_c.size());
        nchk = (mon_q.size() < exp_c.size()) ? mon_q.size() : exp_c.size();
        for (int i = 0; i < nchk; i++) begin
            chk($sformatf("%s:x%0d_cyc", nm, i), mon_q[i].c - s, exp_c[i]);
            chk($sformatf("%s:x%0d_wr", nm, i), mon_q[i].wr, exp_w[i]);
            chk($sformatf("%s:x%0d_addr", nm, i), mon_q[i].a, exp_a[i]);
            chk($sformatf("%s:x%0d_data", nm, i), mon_q[i].d, exp_d[i]);
        end
        chk({nm, ":stable"}, stab_bad, 0);
        pc = psel_cnt;
        repeat (6) @(negedge clk);
        chk({nm, ":idle_bus"}, psel_cnt - pc, 0);
        chk({nm, ":held"}, done_o | error_o, 1);
    endtask

    initial begin
        int ok;
        clr_knobs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst:psel", psel_o, 0);
        chk("rst:penable", penable_o, 0);
        chk("rst:busy", busy_o, 0);
        chk("rst:done", done_o, 0);
        chk("rst:error", error_o, 0);
        chk("rst:err_code", err_code_o, 0);
        chk("rst:rstn_cluster", rstn_cluster_o, 0);
        chk("rst:paddr", paddr_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        clr_knobs();
        run_case("zero_wait", -1);

        clr_knobs();
        waits[2] = 3;
        run_case("wait3_wr2", -1);

        clr_knobs();
        err_on = 1;
        run_case("slverr_wr1", -1);

        clr_knobs();
        lock_after = 1000;
        run_case("poll_exhaust", -1);

        clr_knobs();
        hang_on = 0;
        run_case("timeout_wr0", -1);

        clr_knobs();
        for (int i = 0; i < 8; i++) waits[i] = $urandom_range(0, 3);
        lock_after = 2;
        run_case("restart_ok", -1);

        for (int it = 0; it < 6; it++) begin
            clr_knobs();
            for (int i = 0; i < 8; i++) waits[i] = $urandom_range(0, 3);
            lock_after = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) err_on = $urandom_range(0, 7);
            run_case($sformatf("rand%0d", it), -1);
        end

        // asynchronous reset while waiting between polls
        clr_knobs();
        lock_after = 2;
        @(posedge clk); #1;
        arm = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        start_i = 1'b0;
        ok = 0;
        for (int n = 0; n < 200 && ok == 0; n++) begin
            @(negedge clk);
            if (mon_q.size() >= N + 1) ok = 1;
        end
        chk("arst:reached_poll", ok, 1);
        repeat (3) @(negedge clk);
        chk("arst:busy_before", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst:busy", busy_o, 0);
        chk("arst:psel", psel_o, 0);
        chk("arst:penable", penable_o, 0);
        chk("arst:done", done_o, 0);
        chk("arst:error", error_o, 0);
        chk("arst:err_code", err_code_o, 0);
        chk("arst:rstn_cluster", rstn_cluster_o, 0);
        chk("arst:paddr", paddr_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst:stays_idle", busy_o, 0);

        clr_knobs();
        for (int i = 0; i < 8; i++) waits[i] = $urandom_range(0, 2);
        lock_after = 1;
        run_case("start_ignored", 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
